// File: rtl/usb_hid_report_arb_pkg.sv
// Shared types for the two-port HID report arbiter.
// The timestamp field exists only when USB_HID_ARB_TIMESTAMP_EN is defined.
package usb_hid_arb_pkg;

    typedef logic [0:0] port_id_t;

    localparam port_id_t USB_HID_PORT_USB1 = 1'b0;
    localparam port_id_t USB_HID_PORT_USB2 = 1'b1;

    localparam int unsigned USB_HID_REPORT_W = 64;
    localparam int unsigned USB_HID_TS_W     = 16;

    // One queue slot: source port, optional push timestamp, raw report bytes.
    typedef struct packed {
        port_id_t                    port;
`ifdef USB_HID_ARB_TIMESTAMP_EN
        logic [USB_HID_TS_W-1:0]     ts;
`endif
        logic [USB_HID_REPORT_W-1:0] report;
    } usb_hid_entry_t;

endpackage

// File: rtl/usb_hid_report_arb_if.sv
// Requester, pop and interrupt signals of the HID report arbiter.
// rd_ts_o is present only when USB_HID_ARB_TIMESTAMP_EN is defined.
interface usb_hid_report_arb_if #(
    parameter int DEPTH    = 8,
    parameter int REPORT_W = 64
);
    logic                     req0_valid_i;
    logic [REPORT_W-1:0]      req0_report_i;
    logic                     req0_ready_o;
    logic                     req1_valid_i;
    logic [REPORT_W-1:0]      req1_report_i;
    logic                     req1_ready_o;
    logic                     rd_valid_o;
    logic [REPORT_W-1:0]      rd_report_o;
    logic                     rd_port_o;
    logic                     rd_en_i;
    logic [$clog2(DEPTH):0]   level_o;
    logic                     irq_o;
    logic                     irq_ack_i;
`ifdef USB_HID_ARB_TIMESTAMP_EN
    logic [15:0]              rd_ts_o;
`endif

    modport slave (
        input  req0_valid_i, req0_report_i, req1_valid_i, req1_report_i,
        input  rd_en_i, irq_ack_i,
        output req0_ready_o, req1_ready_o, rd_valid_o, rd_report_o,
`ifdef USB_HID_ARB_TIMESTAMP_EN
        output rd_ts_o,
`endif
        output rd_port_o, level_o, irq_o
    );

    modport master (
        output req0_valid_i, req0_report_i, req1_valid_i, req1_report_i,
        output rd_en_i, irq_ack_i,
        input  req0_ready_o, req1_ready_o, rd_valid_o, rd_report_o,
`ifdef USB_HID_ARB_TIMESTAMP_EN
        input  rd_ts_o,
`endif
        input  rd_port_o, level_o, irq_o
    );
endinterface

// File: rtl/usb_hid_rr_arb2.sv
// Two-way round-robin grant: readies depend only on valids, full and last_grant.
module usb_hid_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] valid_s,
    input  logic       full_s,
    output logic [1:0] ready_s
);
    logic last_grant_r;

    // Grant selection; on contention the port that did not win last time goes.
    always_comb begin
        ready_s = 2'b00;
        if (full_s) begin
            ready_s = 2'b00;
        end else begin
            case (valid_s)
                2'b01:   ready_s = 2'b01;
                2'b10:   ready_s = 2'b10;
                2'b11:   ready_s = last_grant_r ? 2'b01 : 2'b10;
                default: ready_s = 2'b00;
            endcase
        end
    end

    // Remember the port of the most recent transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_r <= 1'b1;
        end else if (valid_s[0] && ready_s[0]) begin
            last_grant_r <= 1'b0;
        end else if (valid_s[1] && ready_s[1]) begin
            last_grant_r <= 1'b1;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
endmodule

// File: rtl/usb_hid_report_arb.sv
// Shared HID report queue fed by usb1/usb2 via round-robin, with sticky irq.
// Optional push timestamps: define USB_HID_ARB_TIMESTAMP_EN.
module usb_hid_report_arb
    import usb_hid_arb_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int REPORT_W = USB_HID_REPORT_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    usb_hid_report_arb_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    usb_hid_entry_t      mem_r [DEPTH];
    usb_hid_entry_t      wr_entry_s;
    usb_hid_entry_t      head_s;
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [LVL_W-1:0]    level_r;
    logic [LVL_W-1:0]    level_nxt_s;
    logic                rd_valid_r;
    logic                irq_r;
    logic [1:0]          valid_s;
    logic [1:0]          ready_s;
    logic                full_s;
    logic                push_s;
    logic                pop_s;
    logic [REPORT_W-1:0] push_report_s;
`ifdef USB_HID_ARB_TIMESTAMP_EN
    logic [15:0]         ts_cnt_r;
`endif

    assign valid_s = {bus.req1_valid_i, bus.req0_valid_i};
    assign full_s  = (level_r == LVL_W'(DEPTH));
    assign push_s  = |(valid_s & ready_s);
    assign pop_s   = bus.rd_en_i && rd_valid_r;

    usb_hid_rr_arb2 u_arb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_s (valid_s),
        .full_s  (full_s),
        .ready_s (ready_s)
    );

    // Build the slot written on a push from whichever port was granted.
    always_comb begin
        wr_entry_s    = '0;
        push_report_s = bus.req0_report_i;
        if (ready_s[1]) begin
            push_report_s   = bus.req1_report_i;
            wr_entry_s.port = USB_HID_PORT_USB2;
        end else begin
            push_report_s   = bus.req0_report_i;
            wr_entry_s.port = USB_HID_PORT_USB1;
        end
        wr_entry_s.report = push_report_s;
`ifdef USB_HID_ARB_TIMESTAMP_EN
        wr_entry_s.ts = ts_cnt_r;
`endif
    end

    // Occupancy after this edge; a simultaneous push and pop cancel out.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_W'(1);
            2'b01:   level_nxt_s = level_r - LVL_W'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Queue storage; contents are meaningless until the pointers cover them.
    always_ff @(posedge clk_i) begin
        if (push_s && !rst_i) begin
            mem_r[wr_ptr_r] <= wr_entry_s;
        end
    end

    // Pointers, level, non-empty flag and sticky interrupt.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r   <= PTR_W'(0);
            rd_ptr_r   <= PTR_W'(0);
            level_r    <= LVL_W'(0);
            rd_valid_r <= 1'b0;
            irq_r      <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            level_r    <= level_nxt_s;
            rd_valid_r <= (level_nxt_s != LVL_W'(0));
            // A push in the same cycle as an ack keeps the interrupt raised.
            if (push_s) begin
                irq_r <= 1'b1;
            end else if (bus.irq_ack_i) begin
                irq_r <= 1'b0;
            end
        end
    end

`ifdef USB_HID_ARB_TIMESTAMP_EN
    // Free-running cycle stamp captured into each pushed slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts_cnt_r <= 16'h0000;
        end else begin
            ts_cnt_r <= ts_cnt_r + 16'h0001;
        end
    end

    assign bus.rd_ts_o = head_s.ts;
`endif

    assign head_s           = mem_r[rd_ptr_r];
    assign bus.req0_ready_o = ready_s[0];
    assign bus.req1_ready_o = ready_s[1];
    assign bus.rd_valid_o   = rd_valid_r;
    assign bus.rd_report_o  = head_s.report;
    assign bus.rd_port_o    = head_s.port;
    assign bus.level_o      = level_r;
    assign bus.irq_o        = irq_r;
endmodule

// File: tb/tb_usb_hid_report_arb.sv
// Directed bench for usb_hid_report_arb; timestamp checks when USB_HID_ARB_TIMESTAMP_EN is defined.
module tb_usb_hid_report_arb;
    logic clk_s = 1'b0;
    logic rst_s = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    usb_hid_report_arb_if #(.DEPTH(8), .REPORT_W(64)) bus ();

    usb_hid_report_arb #(.DEPTH(8), .REPORT_W(64)) dut (
        .clk_i (clk_s),
        .rst_i (rst_s),
        .bus   (bus)
    );

    always #5 clk_s = ~clk_s;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    task automatic do_reset();
        rst_s = 1'b1;
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        bus.rd_en_i      = 1'b0;
        bus.irq_ack_i    = 1'b0;
        tick();
        tick();
        rst_s = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic exp_port, input logic [63:0] exp_rep);
        check_val({tag, "_valid"}, 64'(bus.rd_valid_o), 64'd1);
        check_val({tag, "_port"}, 64'(bus.rd_port_o), 64'(exp_port));
        check_val({tag, "_report"}, bus.rd_report_o, exp_rep);
        bus.rd_en_i = 1'b1;
        tick();
        bus.rd_en_i = 1'b0;
    endtask

    logic [63:0] rep0 [3];
    logic [63:0] rep1 [3];
    int          idx0;
    int          idx1;
    logic        exp_g0;

    initial begin
        bus.req0_report_i = 64'h0;
        bus.req1_report_i = 64'h0;
        rep0[0] = 64'hAAAA_0000_0000_0000;
        rep0[1] = 64'hAAAA_0000_0000_0001;
        rep0[2] = 64'hAAAA_0000_0000_0002;
        rep1[0] = 64'hBBBB_0000_0000_0000;
        rep1[1] = 64'hBBBB_0000_0000_0001;
        rep1[2] = 64'hBBBB_0000_0000_0002;
        do_reset();

        // Reset state
        check_val("rst_valid", 64'(bus.rd_valid_o), 64'd0);
        check_val("rst_level", 64'(bus.level_o), 64'd0);
        check_val("rst_irq", 64'(bus.irq_o), 64'd0);
        check_val("rst_rdy0", 64'(bus.req0_ready_o), 64'd0);
        check_val("rst_rdy1", 64'(bus.req1_ready_o), 64'd0);

        // Single push from usb1
        bus.req0_valid_i  = 1'b1;
        bus.req0_report_i = 64'h0102030405060708;
        #1;
        check_val("p1_rdy0", 64'(bus.req0_ready_o), 64'd1);
        check_val("p1_rdy1", 64'(bus.req1_ready_o), 64'd0);
        tick();
        bus.req0_valid_i = 1'b0;
        check_val("p1_level", 64'(bus.level_o), 64'd1);
        check_val("p1_irq", 64'(bus.irq_o), 64'd1);
        pop_check("p1", 1'b0, 64'h0102030405060708);
        check_val("p1_empty", 64'(bus.rd_valid_o), 64'd0);

        // Round robin from a fresh reset
        do_reset();
        idx0 = 0;
        idx1 = 0;
        bus.req0_valid_i  = 1'b1;
        bus.req1_valid_i  = 1'b1;
        bus.req0_report_i = rep0[0];
        bus.req1_report_i = rep1[0];
        for (int i = 0; i < 4; i++) begin
            #1;
            exp_g0 = ((i % 2) == 0);
            check_val("rr_rdy0", 64'(bus.req0_ready_o), 64'(exp_g0));
            check_val("rr_rdy1", 64'(bus.req1_ready_o), 64'(!exp_g0));
            tick();
            if (exp_g0) begin
                idx0++;
                bus.req0_report_i = rep0[idx0];
            end else begin
                idx1++;
                bus.req1_report_i = rep1[idx1];
            end
        end
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        check_val("rr_level", 64'(bus.level_o), 64'd4);
        pop_check("rr0", 1'b0, rep0[0]);
        pop_check("rr1", 1'b1, rep1[0]);
        pop_check("rr2", 1'b0, rep0[1]);
        pop_check("rr3", 1'b1, rep1[1]);
        check_val("rr_drained", 64'(bus.level_o), 64'd0);

        // Fill to full, then pop with both requesters waiting
        bus.req0_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.req0_report_i = 64'hF000 + 64'(i);
            #1;
            check_val("fill_rdy0", 64'(bus.req0_ready_o), 64'd1);
            tick();
        end
        check_val("full_level", 64'(bus.level_o), 64'd8);
        bus.req0_report_i = 64'hF008;
        bus.req1_valid_i  = 1'b1;
        bus.req1_report_i = 64'hC1;
        #1;
        check_val("full_rdy0", 64'(bus.req0_ready_o), 64'd0);
        check_val("full_rdy1", 64'(bus.req1_ready_o), 64'd0);
        bus.rd_en_i = 1'b1;
        #1;
        check_val("fullpop_rdy0", 64'(bus.req0_ready_o), 64'd0);
        check_val("fullpop_rdy1", 64'(bus.req1_ready_o), 64'd0);
        tick();
        bus.rd_en_i = 1'b0;
        check_val("fullpop_level", 64'(bus.level_o), 64'd7);
        #1;
        check_val("refill_rdy0", 64'(bus.req0_ready_o), 64'd0);
        check_val("refill_rdy1", 64'(bus.req1_ready_o), 64'd1);
        tick();
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        check_val("refill_level", 64'(bus.level_o), 64'd8);
        for (int i = 1; i < 8; i++) begin
            pop_check("drain", 1'b0, 64'hF000 + 64'(i));
        end
        pop_check("drain_last", 1'b1, 64'hC1);
        check_val("drain_level", 64'(bus.level_o), 64'd0);

        // Pop while empty is ignored
        bus.rd_en_i = 1'b1;
        tick();
        bus.rd_en_i = 1'b0;
        check_val("uflow_level", 64'(bus.level_o), 64'd0);
        check_val("uflow_valid", 64'(bus.rd_valid_o), 64'd0);
        bus.req1_valid_i  = 1'b1;
        bus.req1_report_i = 64'h0123_4567_89AB_CDEF;
        tick();
        bus.req1_valid_i = 1'b0;
        check_val("uflow_push_level", 64'(bus.level_o), 64'd1);
        pop_check("uflow", 1'b1, 64'h0123_4567_89AB_CDEF);
        check_val("uflow_pop_level", 64'(bus.level_o), 64'd0);

        // Interrupt acknowledge versus push
        bus.irq_ack_i = 1'b1;
        tick();
        bus.irq_ack_i = 1'b0;
        check_val("irq_ack", 64'(bus.irq_o), 64'd0);
        bus.req0_valid_i  = 1'b1;
        bus.req0_report_i = 64'h55;
        bus.irq_ack_i     = 1'b1;
        tick();
        bus.req0_valid_i = 1'b0;
        bus.irq_ack_i    = 1'b0;
        check_val("irq_set_wins", 64'(bus.irq_o), 64'd1);
        bus.irq_ack_i = 1'b1;
        tick();
        bus.irq_ack_i = 1'b0;
        check_val("irq_ack2", 64'(bus.irq_o), 64'd0);
        pop_check("irq_entry", 1'b0, 64'h55);

        // Reset mid-operation discards entries and voids the handshake
        bus.req0_valid_i  = 1'b1;
        bus.req0_report_i = 64'h77;
        tick();
        tick();
        check_val("mid_level", 64'(bus.level_o), 64'd2);
        rst_s = 1'b1;
        bus.req1_valid_i = 1'b1;
        tick();
        rst_s = 1'b0;
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
        check_val("mid_rst_level", 64'(bus.level_o), 64'd0);
        check_val("mid_rst_valid", 64'(bus.rd_valid_o), 64'd0);
        check_val("mid_rst_irq", 64'(bus.irq_o), 64'd0);
        tick();
        check_val("mid_rst_hold", 64'(bus.level_o), 64'd0);

`ifdef USB_HID_ARB_TIMESTAMP_EN
        // Timestamps: pushes at counter values 5 and 12, then across the wrap
        do_reset();
        repeat (5) tick();
        bus.req0_valid_i = 1'b1;
        bus.req0_report_i = 64'h5;
        tick();
        bus.req0_valid_i = 1'b0;
        repeat (6) tick();
        bus.req0_valid_i = 1'b1;
        bus.req0_report_i = 64'hC;
        tick();
        bus.req0_valid_i = 1'b0;
        check_val("ts_first", 64'(bus.rd_ts_o), 64'd5);
        pop_check("ts_e0", 1'b0, 64'h5);
        check_val("ts_second", 64'(bus.rd_ts_o), 64'd12);
        pop_check("ts_e1", 1'b0, 64'hC);
        repeat (65535 - 15) tick();
        bus.req0_valid_i = 1'b1;
        bus.req0_report_i = 64'hE;
        tick();
        tick();
        bus.req0_valid_i = 1'b0;
        check_val("ts_ffff", 64'(bus.rd_ts_o), 64'hFFFF);
        pop_check("ts_e2", 1'b0, 64'hE);
        check_val("ts_wrap", 64'(bus.rd_ts_o), 64'h0);
        pop_check("ts_e3", 1'b0, 64'hE);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
